// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  size_t;

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    LS_RD,
    LS_WR
  } state_e;

  // Reads here have side effects, so addresses are never issued speculatively.
  localparam addr_t IO_BASE    = 32'h0003_0000;
  localparam size_t FETCH_SIZE = 3'd4;

  function automatic byte_t lane(input word_t w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and byte-wide memory bus signals of mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic  if_req;
  addr_t if_addr;
  logic  if_cancel;
  logic  if_done;
  word_t if_data;

  logic  ls_req;
  logic  ls_wr;
  addr_t ls_addr;
  size_t ls_size;
  word_t ls_wdata;
  logic  ls_done;
  word_t ls_rdata;

  byte_t mem_din;
  byte_t mem_dout;
  addr_t mem_a;
  logic  mem_wr;

  modport slave (
    input  if_req, if_addr, if_cancel, ls_req, ls_wr, ls_addr, ls_size, ls_wdata, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, if_cancel, ls_req, ls_wr, ls_addr, ls_size, ls_wdata, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch vs load/store onto an 8-bit
// synchronous RAM/IO bus with one cycle of read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic      clk,
  input logic      rst,
  input logic      rdy,
  mem_ctrl_if.slave bus
);

  state_e state_q, state_d;
  addr_t  base_q, base_d;
  size_t  size_q, size_d;
  size_t  cap_q, cap_d;
  size_t  iss_q, iss_d;
  logic   pend_q, pend_d;
  word_t  wdata_q, wdata_d;
  word_t  buf_q, buf_d;
  word_t  if_data_q, if_data_d;
  word_t  ls_rdata_q, ls_rdata_d;
  logic   if_done_q, if_done_d;
  logic   ls_done_q, ls_done_d;

  addr_t  mem_a;
  logic   mem_wr;
  byte_t  mem_dout;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    cap_d      = cap_q;
    iss_d      = iss_q;
    pend_d     = pend_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;

    if (rdy) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          cap_d  = '0;
          iss_d  = '0;
          pend_d = 1'b0;
          buf_d  = '0;
          // The done cycle still sees the requester's held request; ignore it.
          if (!(if_done_q || ls_done_q)) begin
            if (bus.ls_req) begin
              state_d = bus.ls_wr ? LS_WR : LS_RD;
              base_d  = bus.ls_addr;
              size_d  = bus.ls_size;
              wdata_d = bus.ls_wdata;
            end else if (bus.if_req && !bus.if_cancel) begin
              state_d = IF_RD;
              base_d  = bus.if_addr;
              size_d  = FETCH_SIZE;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (pend_q) begin
            buf_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
            cap_d = cap_q + 3'd1;
          end
          pend_d = 1'b0;
          if (iss_q < size_q) begin
            mem_a  = base_q + {29'd0, iss_q};
            iss_d  = iss_q + 3'd1;
            pend_d = 1'b1;
          end
          if (state_q == IF_RD && bus.if_cancel) begin
            state_d = IDLE;
          end else if (pend_q && cap_q == size_q - 3'd1) begin
            state_d = IDLE;
            if (state_q == IF_RD) begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end else begin
              ls_rdata_d = buf_d;
              ls_done_d  = 1'b1;
            end
          end
        end
        LS_WR: begin
          if (iss_q < size_q) begin
            mem_wr   = 1'b1;
            mem_a    = base_q + {29'd0, iss_q};
            mem_dout = lane(wdata_q, iss_q[1:0]);
            iss_d    = iss_q + 3'd1;
            if (iss_q == size_q - 3'd1) begin
              state_d   = IDLE;
              ls_done_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IF_RD || state_q == LS_RD) begin
      // The byte in flight is dropped, so issue restarts at the first uncaptured byte.
      iss_d  = cap_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      size_q     <= '0;
      cap_q      <= '0;
      iss_q      <= '0;
      pend_q     <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      cap_q      <= cap_d;
      iss_q      <= iss_d;
      pend_q     <= pend_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign bus.if_done  = if_done_q & rdy;
  assign bus.ls_done  = ls_done_q & rdy;
  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.mem_a    = mem_a;
  assign bus.mem_wr   = mem_wr;
  assign bus.mem_dout = mem_dout;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and done-pulse scoreboards.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic rdy;
  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    io_hits = 0;
  int    wr_cnt = 0;
  word_t if_q[$];
  word_t ls_q[$];
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Synchronous RAM: address sampled at the edge, byte presented next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_done) begin
        if (if_q.size() == 0) chk("if_spurious_done", 32'd1, 32'd0);
        else chk("if_data", bus.if_data, if_q.pop_front());
      end
      if (bus.ls_done) begin
        if (ls_q.size() == 0) chk("ls_spurious_done", 32'd1, 32'd0);
        else chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
      end
      if (bus.mem_a == IO_BASE) io_hits++;
      if (bus.mem_wr) wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_done(input bit is_ls, output int c);
    c = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (is_ls ? bus.ls_done : bus.if_done) begin
        c = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (c < 0) chk(is_ls ? "ls_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t;
    int c;
    int base_cnt;
    word_t ls_model;

    rst = 1'b1;
    rdy = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_cancel = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_wr = 1'b0;
    bus.ls_addr = '0;
    bus.ls_size = '0;
    bus.ls_wdata = '0;
    ls_model = '0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h1004] = 8'h93; ram[32'h1005] = 8'h00; ram[32'h1006] = 8'h10; ram[32'h1007] = 8'h00;
    ram[IO_BASE] = 8'h5A;

    step(); step(); mid();
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("rst_if_done", {31'd0, bus.if_done}, 32'h0);
    chk("rst_ls_done", {31'd0, bus.ls_done}, 32'h0);
    step();
    rst = 1'b0;

    // 4-byte fetch at 0x1000
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h1000; t = cyc;
    if_q.push_back(32'h0000_0513);
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      chk("fetch_mem_a", bus.mem_a, 32'h1000 + i);
      chk("fetch_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    end
    step(); mid();
    chk("fetch_no_overrun", bus.mem_a, 32'h0);
    wait_done(1'b0, c);
    chk("fetch_latency", c - t, 32'd6);
    step();
    bus.if_req = 1'b0;

    // Store and fetch requested together: store wins
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 3'd2;
    bus.ls_addr = 32'h2002; bus.ls_wdata = 32'hAABB_CCDD;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    t = cyc; base_cnt = wr_cnt;
    ls_q.push_back(ls_model);
    if_q.push_back(32'h0000_0513);
    step(); mid();
    chk("st_wr0", {31'd0, bus.mem_wr}, 32'h1);
    chk("st_a0", bus.mem_a, 32'h2002);
    chk("st_d0", {24'd0, bus.mem_dout}, 32'hDD);
    step(); mid();
    chk("st_wr1", {31'd0, bus.mem_wr}, 32'h1);
    chk("st_a1", bus.mem_a, 32'h2003);
    chk("st_d1", {24'd0, bus.mem_dout}, 32'hCC);
    wait_done(1'b1, c);
    chk("st_latency", c - t, 32'd3);
    step();
    bus.ls_req = 1'b0;
    mid();
    chk("st_then_idle", bus.mem_a, 32'h0);
    step(); mid();
    chk("fetch_after_store", bus.mem_a, 32'h1000);
    wait_done(1'b0, c);
    chk("fetch_after_store_lat", c - t, 32'd10);
    step();
    bus.if_req = 1'b0;
    chk("st_write_count", wr_cnt - base_cnt, 32'd2);
    chk("st_ram_2002", {24'd0, ram_rd(32'h2002)}, 32'hDD);
    chk("st_ram_2003", {24'd0, ram_rd(32'h2003)}, 32'hCC);
    chk("st_ram_2004", {24'd0, ram_rd(32'h2004)}, 32'h00);

    // Single-byte IO load
    base_cnt = io_hits;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 3'd1; bus.ls_addr = IO_BASE;
    t = cyc;
    ls_model = 32'h0000_005A;
    ls_q.push_back(ls_model);
    wait_done(1'b1, c);
    chk("io_latency", c - t, 32'd3);
    step();
    bus.ls_req = 1'b0;
    step(); mid();
    chk("io_single_access", io_hits - base_cnt, 32'd1);
    step();

    // Cancel during the third fetch byte, then a fresh fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    step(); step(); step();
    bus.if_cancel = 1'b1;
    mid();
    chk("cancel_third_byte", bus.mem_a, 32'h1002);
    step();
    bus.if_cancel = 1'b0; bus.if_addr = 32'h1004; t = cyc;
    if_q.push_back(32'h0010_0093);
    mid();
    chk("cancel_idle_a", bus.mem_a, 32'h0);
    chk("cancel_no_done", {31'd0, bus.if_done}, 32'h0);
    step(); mid();
    chk("refetch_a", bus.mem_a, 32'h1004);
    wait_done(1'b0, c);
    chk("refetch_latency", c - t, 32'd6);
    step();
    bus.if_req = 1'b0;

    // 4-byte load paused for 3 cycles during the second byte
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 3'd4; bus.ls_addr = 32'h1000;
    t = cyc;
    ls_model = 32'h0000_0513;
    ls_q.push_back(ls_model);
    step(); step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("pause_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
      chk("pause_ls_done", {31'd0, bus.ls_done}, 32'h0);
      step();
    end
    rdy = 1'b1;
    wait_done(1'b1, c);
    chk("pause_delayed", {31'd0, (c - t) >= 9}, 32'h1);
    step();
    bus.ls_req = 1'b0;

    // Reset in the middle of a 4-byte store
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 3'd4;
    bus.ls_addr = 32'h4000; bus.ls_wdata = 32'h1122_3344;
    step(); mid();
    chk("rst_st_first_byte", {24'd0, bus.mem_dout}, 32'h44);
    step();
    rst = 1'b1;
    bus.ls_req = 1'b0;
    ls_model = '0;
    step(); mid();
    chk("midrst_mem_a", bus.mem_a, 32'h0);
    chk("midrst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("midrst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("midrst_if_done", {31'd0, bus.if_done}, 32'h0);
    chk("midrst_ls_done", {31'd0, bus.ls_done}, 32'h0);
    chk("midrst_if_data", bus.if_data, 32'h0);
    chk("midrst_ls_rdata", bus.ls_rdata, ls_model);
    base_cnt = wr_cnt;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("postrst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
      step();
    end
    chk("postrst_write_count", wr_cnt - base_cnt, 32'd0);
    chk("postrst_ram_4002", {24'd0, ram_rd(32'h4002)}, 32'h00);
    chk("postrst_ram_4003", {24'd0, ram_rd(32'h4003)}, 32'h00);
    chk("if_queue_drained", if_q.size(), 32'd0);
    chk("ls_queue_drained", ls_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
